// File: rtl/prf_free_list.sv
// prf_free_list: circular free list of physical register numbers with speculative and retired heads
module prf_free_list #(
  parameter int PRF_DEPTH     = 64,
  parameter int ARF_DEPTH     = 32,
  parameter int MACHINE_WIDTH = 4,
  parameter int PRF_WIDTH     = $clog2(PRF_DEPTH),
  parameter int FL_DEPTH      = PRF_DEPTH - ARF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_flush,
  output logic [PRF_WIDTH-1:0]     free_prn [MACHINE_WIDTH],
  output logic [MACHINE_WIDTH-1:0] free_prn_valid,
  input  logic [MACHINE_WIDTH-1:0] free_prn_ready,
  input  logic [PRF_WIDTH-1:0]     release_prn [MACHINE_WIDTH],
  input  logic [MACHINE_WIDTH-1:0] release_valid,
  input  logic [MACHINE_WIDTH-1:0] commit_alloc_valid,
  output logic [PRF_WIDTH:0]       num_free,
  output logic                     overflow_err
);
  localparam int IW = $clog2(FL_DEPTH);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(MACHINE_WIDTH + 1);
  logic [PRF_WIDTH-1:0]     mem [FL_DEPTH];
  logic [PW-1:0]            head, arch_head, tail, count, head_n, arch_head_n, tail_n;
  logic [CW-1:0]            alloc_cnt, rel_cnt, commit_cnt;
  logic [CW-1:0]            rel_off [MACHINE_WIDTH];
  logic [MACHINE_WIDTH-1:0] acc;
  logic [PW:0]              after;
  logic                     started, run, prefix_err, drop, arch_err;
  assign count    = tail - head;
  assign num_free = (PRF_WIDTH+1)'(count);
  // offers come straight from registered state; nothing offered before the first edge or during flush
  always_comb begin
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      free_prn[i]       = mem[IW'(head + PW'(i))];
      free_prn_valid[i] = started && (count > PW'(i)) && !pipe_flush;
    end
  end
  // lane counts, release compaction offsets, next pointers and error detection
  always_comb begin
    acc        = free_prn_valid & free_prn_ready;
    alloc_cnt  = '0;
    rel_cnt    = '0;
    commit_cnt = '0;
    run        = 1'b1;
    prefix_err = 1'b0;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      run        = run & acc[i];
      prefix_err = prefix_err | (acc[i] & !run);
      alloc_cnt  = alloc_cnt + CW'(run);
      rel_off[i] = rel_cnt;
      rel_cnt    = rel_cnt + CW'(release_valid[i]);
      commit_cnt = commit_cnt + CW'(commit_alloc_valid[i]);
    end
    after       = {1'b0, count} - (PW+1)'(alloc_cnt) + (PW+1)'(rel_cnt);
    drop        = after > (PW+1)'(FL_DEPTH);
    arch_head_n = arch_head + PW'(commit_cnt);
    head_n      = pipe_flush ? arch_head_n : head + PW'(alloc_cnt);
    tail_n      = drop ? tail : tail + PW'(rel_cnt);
    arch_err    = (tail_n - arch_head_n) > PW'(FL_DEPTH);
  end
  // pointer, storage and sticky-error update; reset refills the list with the unmapped PRNs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FL_DEPTH; k++) mem[k] <= PRF_WIDTH'(ARF_DEPTH + k);
      head         <= '0;
      arch_head    <= '0;
      tail         <= PW'(FL_DEPTH);
      started      <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      for (int i = 0; i < MACHINE_WIDTH; i++)
        if (release_valid[i] && !drop) mem[IW'(tail + PW'(rel_off[i]))] <= release_prn[i];
      head         <= head_n;
      arch_head    <= arch_head_n;
      tail         <= tail_n;
      started      <= 1'b1;
      overflow_err <= overflow_err | prefix_err | drop | arch_err;
    end
  end
endmodule

// File: tb/tb_prf_free_list.sv
// tb_prf_free_list: queue-based reference model plus directed and constrained-random stimulus
module tb_prf_free_list;
  logic       clk = 1'b0, rst_n = 1'b0, pipe_flush = 1'b0;
  logic [5:0] free_prn [4];
  logic [3:0] free_prn_valid, free_prn_ready, release_valid, commit_alloc_valid;
  logic [5:0] release_prn [4];
  logic [6:0] num_free;
  logic       overflow_err;
  int         checks = 0, errors = 0;
  logic [5:0] freeq [$];
  logic [5:0] specq [$];
  bit         m_err, m_started;

  prf_free_list dut (
    .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
    .free_prn(free_prn), .free_prn_valid(free_prn_valid), .free_prn_ready(free_prn_ready),
    .release_prn(release_prn), .release_valid(release_valid),
    .commit_alloc_valid(commit_alloc_valid), .num_free(num_free), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, a, e);
    end
  endtask

  function automatic logic [3:0] mvalid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_started && (freeq.size() > i) && !pipe_flush;
    return v;
  endfunction

  task automatic idle();
    free_prn_ready = '0; release_valid = '0; commit_alloc_valid = '0; pipe_flush = 1'b0;
    release_prn = '{6'd0, 6'd0, 6'd0, 6'd0};
  endtask

  task automatic model_reset();
    freeq.delete(); specq.delete();
    for (int k = 0; k < 32; k++) freeq.push_back(6'(32 + k));
    m_err = 1'b0; m_started = 1'b0;
  endtask

  task automatic model_edge();
    logic [3:0] acc;
    int alloc, rel, com;
    bit run, perr, drop;
    acc = mvalid() & free_prn_ready;
    alloc = 0; run = 1'b1; perr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!acc[i]) run = 1'b0;
      else if (run) alloc++;
      else perr = 1'b1;
    end
    rel = $countones(release_valid);
    com = $countones(commit_alloc_valid);
    drop = (freeq.size() - alloc + rel) > 32;
    repeat (alloc) specq.push_back(freeq.pop_front());
    repeat (com) if (specq.size() > 0) void'(specq.pop_front());
    if (pipe_flush) begin
      freeq = {specq, freeq};
      specq.delete();
    end
    if (!drop) for (int i = 0; i < 4; i++) if (release_valid[i]) freeq.push_back(release_prn[i]);
    if (perr || drop || (specq.size() + freeq.size() > 32)) m_err = 1'b1;
    m_started = 1'b1;
  endtask

  task automatic compare();
    logic [3:0] mv;
    mv = mvalid();
    chk("num_free", num_free, freeq.size());
    chk("free_prn_valid", free_prn_valid, mv);
    chk("overflow_err", overflow_err, m_err);
    for (int i = 0; i < 4; i++) if (mv[i]) chk($sformatf("free_prn[%0d]", i), free_prn[i], freeq[i]);
  endtask

  task automatic cycle();
    #1 compare();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    model_reset();
    #1;
    chk("rst num_free", num_free, 32);
    chk("rst valid", free_prn_valid, 0);
    chk("rst overflow_err", overflow_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] cv, rv;
    int k, room;
    idle();
    @(negedge clk);
    do_reset();
    cycle();
    #1;
    chk("init prn0", free_prn[0], 32); chk("init prn1", free_prn[1], 33);
    chk("init prn2", free_prn[2], 34); chk("init prn3", free_prn[3], 35);
    chk("init valid", free_prn_valid, 4'b1111); chk("init num_free", num_free, 32);
    free_prn_ready = 4'b0011;
    cycle();
    free_prn_ready = '0;
    #1;
    chk("alloc2 prn0", free_prn[0], 34); chk("alloc2 prn1", free_prn[1], 35);
    chk("alloc2 prn2", free_prn[2], 36); chk("alloc2 prn3", free_prn[3], 37);
    chk("alloc2 num_free", num_free, 30);
    free_prn_ready = 4'b1111;
    repeat (8) cycle();
    free_prn_ready = '0;
    #1;
    chk("empty num_free", num_free, 0); chk("empty valid", free_prn_valid, 0);
    release_valid = 4'b0101;
    release_prn = '{6'd5, 6'd0, 6'd9, 6'd0};
    cycle();
    idle();
    #1;
    chk("compact prn0", free_prn[0], 5); chk("compact prn1", free_prn[1], 9);
    chk("compact valid", free_prn_valid, 4'b0011);

    do_reset();
    cycle();
    free_prn_ready = 4'b1111;
    repeat (3) cycle();
    free_prn_ready = '0;
    commit_alloc_valid = 4'b1111;
    cycle();
    commit_alloc_valid = '0;
    pipe_flush = 1'b1;
    #1;
    chk("flush valid", free_prn_valid, 0);
    cycle();
    pipe_flush = 1'b0;
    #1;
    chk("restore num_free", num_free, 28); chk("restore prn0", free_prn[0], 36);

    do_reset();
    cycle();
    free_prn_ready = 4'b1111;
    repeat (2) cycle();
    free_prn_ready = '0;
    pipe_flush = 1'b1;
    commit_alloc_valid = 4'b0011;
    release_valid = 4'b0001;
    release_prn[0] = 6'd7;
    cycle();
    idle();
    #1;
    chk("flush+retire num_free", num_free, 31); chk("flush+retire prn0", free_prn[0], 34);
    free_prn_ready = 4'b1111;
    repeat (7) cycle();
    free_prn_ready = '0;
    #1;
    chk("wrap valid", free_prn_valid, 4'b0111); chk("wrap prn2", free_prn[2], 7);
    chk("wrap num_free", num_free, 3); chk("wrap err", overflow_err, 0);

    do_reset();
    cycle();
    release_valid = 4'b0001;
    release_prn[0] = 6'd3;
    cycle();
    idle();
    #1;
    chk("full drop err", overflow_err, 1); chk("full drop num_free", num_free, 32);
    cycle();
    #1;
    chk("sticky err", overflow_err, 1);
    do_reset();
    cycle();
    free_prn_ready = 4'b0101;
    cycle();
    free_prn_ready = '0;
    #1;
    chk("prefix err", overflow_err, 1); chk("prefix num_free", num_free, 31);
    chk("prefix prn0", free_prn[0], 33);
    free_prn_ready = 4'b1111;
    repeat (2) cycle();
    do_reset();

    cycle();
    repeat (300) begin
      k = $urandom_range(0, 4);
      free_prn_ready = 4'((1 << k) - 1);
      cv = 4'($urandom);
      while ($countones(cv) > specq.size()) cv = cv & (cv - 4'd1);
      commit_alloc_valid = cv;
      pipe_flush = ($urandom_range(0, 7) == 0);
      room = 32 - (specq.size() + freeq.size()) + $countones(cv);
      rv = 4'($urandom);
      while ($countones(rv) > room) rv = rv & (rv - 4'd1);
      release_valid = rv;
      for (int i = 0; i < 4; i++) release_prn[i] = 6'($urandom);
      cycle();
    end
    idle();
    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prf_free_list.md
Name: prf_free_list

Overview:
- Circular free list of physical register numbers (PRNs) for the rename stage. Holds every PRN that is not architecturally mapped.
- Offers up to MACHINE_WIDTH PRNs per cycle to rename; accepted PRNs become the free_prn/free_prn_valid/free_prn_ready inputs of the busy table.
- Commit returns stale PRNs at the tail.
- Tracks a retired head pointer so pipe_flush restores all speculatively allocated PRNs in one cycle.

Parameters:
- PRF_DEPTH, 64, number of physical registers.
- ARF_DEPTH, 32, number of architectural registers; also the number of PRNs mapped at reset.
- MACHINE_WIDTH, 4, allocate/release lanes per cycle.
- PRF_WIDTH, 6, PRN width, equal to log2(PRF_DEPTH).
- FL_DEPTH, PRF_DEPTH-ARF_DEPTH (32), free list capacity.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous, active-low reset.
- pipe_flush, in, 1, discard all speculative allocations.
- free_prn[0:MACHINE_WIDTH-1], out, PRF_WIDTH each, PRN offered on lane i.
- free_prn_valid, out, MACHINE_WIDTH, lane i offer valid.
- free_prn_ready, in, MACHINE_WIDTH, rename accepts lane i.
- release_prn[0:MACHINE_WIDTH-1], in, PRF_WIDTH each, stale PRN freed at retire.
- release_valid, in, MACHINE_WIDTH, release lane valid.
- commit_alloc_valid, in, MACHINE_WIDTH, retiring instruction on lane i had allocated a PRN.
- num_free, out, PRF_WIDTH+1, current speculative free count.
- overflow_err, out, 1, sticky protocol-error flag.

Behaviour:
- Storage:
  - FL_DEPTH entries, indexed by pointers of log2(FL_DEPTH)+1 bits (MSB is the wrap bit).
  - Pointers: head (speculative), arch_head (retired), tail.
  - Count = tail-head, modulo 2^(log2(FL_DEPTH)+1).
- Reset (async):
  - entry k = ARF_DEPTH+k for k = 0..FL_DEPTH-1.
  - head = arch_head = 0; tail = FL_DEPTH with wrap bit set, i.e. full.
  - num_free = FL_DEPTH; free_prn_valid = 0 until the first clock edge after reset release; overflow_err = 0.
- Offer (combinational from registered state):
  - free_prn[i] = entry[head+i].
  - free_prn_valid[i] = (count > i) && !pipe_flush.
  - No bypass of same-cycle releases.
- Allocate:
  - alloc_cnt = popcount(free_prn_valid & free_prn_ready).
  - Accepted lanes must be a prefix (lanes 0..k-1). A non-prefix pattern sets overflow_err and consumes only the prefix.
  - head += alloc_cnt at the clock edge. Accepted PRNs are removed that edge, zero-cycle latency to the busy table.
- Release:
  - Valid lanes are compacted in lane order and written at tail, tail+1, ...; tail += popcount(release_valid).
  - Invalid lanes may sit anywhere in the vector.
- Retire: arch_head += popcount(commit_alloc_valid).
- Flush cycle:
  - Allocation is suppressed.
  - Retire and release of that cycle are applied.
  - head_next = arch_head + commit_cnt; tail_next = tail + release_cnt.
  - Offers resume the next cycle.
- Full:
  - A release that would make count exceed FL_DEPTH is dropped (tail unchanged) and sets overflow_err.
  - The arch_head/tail distance also exceeding FL_DEPTH sets overflow_err.
- Empty: count = 0 means all free_prn_valid = 0. Same-cycle allocate and release are legal.
- Wrap-around: pointers wrap modulo 2·FL_DEPTH; entry index = pointer LSBs.
- overflow_err is cleared only by reset.
- num_free is the registered count.
- Reset mid-operation returns every state element to its reset value immediately.

Test Plan:
- Reset, then idle one cycle -> free_prn = {32,33,34,35}, free_prn_valid = 4'b1111, num_free = 32.
- free_prn_ready = 4'b0011 for one cycle -> next cycle free_prn = {34,35,36,37}, num_free = 30.
- Allocate 4/cycle for 8 cycles -> num_free = 0 and valid = 0. Then release_valid = 4'b0101 with PRNs {5,x,9,x} -> next cycle free_prn[0] = 5, free_prn[1] = 9, valid = 4'b0011.
- Allocate 12, retire with commit_alloc_valid totalling 4, then pipe_flush -> valid = 0 in the flush cycle. Next cycle num_free = 28, free_prn[0] = 36.
- Flush with commit_alloc_valid = 4'b0011 and release_valid = 4'b0001 (PRN 7) in the same cycle -> arch_head advances 2 before the restore; tail holds PRN 7.
- From reset (full), release_valid = 4'b0001 -> release dropped, overflow_err = 1 and stays 1. free_prn_ready = 4'b0101 -> overflow_err = 1 and only lane 0 is consumed.
